rx_oper: RTL

//  Low-level RGMII receive block, the receive-side counterpart of the transmit operator.
//  - Captures DDR rxd/rx_ctl from the PHY and assembles bytes.
//  - Strips preamble/SFD and delivers frame bytes as a valid/last/user stream to the MAC

---
 rtl/eth_pkg.sv | 20 ++
 rtl/rgmii_rx_capture.sv | 64 ++++++
 rtl/rx_oper.sv | 106 ++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Ethernet constants and receive-side types shared by the RGMII rx blocks.
package eth_pkg;

  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD      = 8'hD5;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_PREAMBLE = 2'd1,
    RX_DATA     = 2'd2,
    RX_DROP     = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       dv;
    logic       er;
    logic [7:0] data;
  } rx_cap_t;

endpackage

// File: rtl/rgmii_rx_capture.sv
// RGMII DDR input capture: per-pin rise/fall sampling, realigned to the rising
// edge (same-edge-pipelined), then one capture register producing dv/er/byte.
module rgmii_rx_capture
  import eth_pkg::*;
#(
  parameter int USE_IDDR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_ctl_i,
  input  logic [3:0] rxd_i,
  output rx_cap_t    cap_o
);

  logic [4:0] pin;
  logic [4:0] rise_n, fall_n;
  logic [4:0] rise_q, fall_q;
  rx_cap_t    cap_q;

  assign pin = {rx_ctl_i, rxd_i};

  for (genvar b = 0; b < 5; b++) begin : g_bit
    if (USE_IDDR != 0) begin : g_iob
      // First-stage flops pinned into the input tile so they map onto the IDDR site.
      (* IOB = "TRUE" *) logic r_q;
      (* IOB = "TRUE" *) logic f_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= pin[b];
      always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) f_q <= 1'b0;
        else        f_q <= pin[b];
      assign rise_n[b] = r_q;
      assign fall_n[b] = f_q;
    end else begin : g_beh
      logic r_q, f_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= pin[b];
      always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) f_q <= 1'b0;
        else        f_q <= pin[b];
      assign rise_n[b] = r_q;
      assign fall_n[b] = f_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
      cap_q  <= '0;
    end else begin
      rise_q     <= rise_n;
      fall_q     <= fall_n;
      cap_q.dv   <= rise_q[4];
      cap_q.er   <= rise_q[4] ^ fall_q[4];
      cap_q.data <= {fall_q[3:0], rise_q[3:0]};
    end
  end

  assign cap_o = cap_q;

endmodule

// File: rtl/rx_oper.sv
// RGMII receive operator: strips preamble/SFD and streams frame bytes with
// tlast/tuser, one byte held back so the last beat is known when dv drops.
module rx_oper
  import eth_pkg::*;
#(
  parameter int USE_IDDR  = 1,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_ctl,
  input  logic [3:0] rxd,
  output logic       m_tvalid,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       m_tuser
);

  localparam int CW = $clog2(MAX_FRAME + 1);

  rx_cap_t        cap;
  rx_state_e      state_q;
  logic [CW-1:0]  cnt_q;
  logic           err_q;
  logic [7:0]     hold_q;
  logic           tvalid_q, tlast_q, tuser_q;
  logic [7:0]     tdata_q;

  rgmii_rx_capture #(.USE_IDDR(USE_IDDR)) u_cap (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_ctl_i (rx_ctl),
    .rxd_i    (rxd),
    .cap_o    (cap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      hold_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      case (state_q)
        RX_IDLE, RX_PREAMBLE: begin
          if (!cap.dv)
            state_q <= RX_IDLE;
          else if (state_q == RX_PREAMBLE && cap.er)
            state_q <= RX_DROP;
          else if (cap.data == ETH_SFD) begin
            state_q <= RX_DATA;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end else if (cap.data == ETH_PREAMBLE)
            state_q <= RX_PREAMBLE;
          else
            state_q <= RX_DROP;
        end
        RX_DATA: begin
          if (cap.dv) begin
            if (cnt_q == CW'(MAX_FRAME)) begin
              // Oversize: close the frame on the byte already held, discard the rest.
              tvalid_q <= 1'b1;
              tdata_q  <= hold_q;
              tlast_q  <= 1'b1;
              tuser_q  <= 1'b1;
              state_q  <= RX_DROP;
            end else begin
              if (cnt_q != '0) begin
                tvalid_q <= 1'b1;
                tdata_q  <= hold_q;
              end
              hold_q <= cap.data;
              cnt_q  <= cnt_q + CW'(1);
              err_q  <= err_q | cap.er;
            end
          end else begin
            state_q <= RX_IDLE;
            if (cnt_q != '0) begin
              tvalid_q <= 1'b1;
              tdata_q  <= hold_q;
              tlast_q  <= 1'b1;
              tuser_q  <= err_q | (cnt_q < CW'(MIN_FRAME));
            end
          end
        end
        RX_DROP: if (!cap.dv) state_q <= RX_IDLE;
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;
  assign m_tuser  = tuser_q;

endmodule
